ads1115_avg_filter: RTL and testbench
=====================================

// Module: ads1115_avg_filter
// PURPOSE
//   Boxcar moving-average filter placed directly downstream of the ADS1115 polling driver.
//   Consumes each signed 16-bit conversion pulse (data + valid) and keeps a circular
//   buffer of the last 2^LOG2_N samples plus a running sum.
//   Emits one averaged signed sample per accepted input once the window is full.
//   Output feeds the display/UART reporting stage.
// PARAMETERS
//   LOG2_N    4    log2 of window depth; window = 2^LOG2_N samples; legal range 1..8
// PORTS
//   i_clk          in   1         system clock; single clock domain
//   i_rst          in   1         synchronous reset, active-high
//   i_data         in   16        signed sample from ADC driver; sampled when i_valid=1
//   i_valid        in   1         single-cycle sample strobe
//   i_clear        in   1         synchronous flush of window, sum and fill count
//   o_avg          out  16        signed window average
//   o_avg_valid    out  1         single-cycle pulse when o_avg updates
//   o_primed       out  1         high once 2^LOG2_N samples are in the window
//   o_overrun      out  1         single-cycle pulse: i_valid arrived while busy (sample dropped)
//   o_min, o_max   out  16 each   signed running extremes (MINMAX only)
// BEHAVIOUR
//   Reset: all outputs 0; wr_ptr=0, fill=0, sum=0, state S_IDLE; buffer contents don't-care.
//   FSM: S_IDLE -(i_valid)-> S_READ -> S_UPDATE -> S_IDLE.
//     S_IDLE:   on i_valid, latch i_data; issue sync read of buf[wr_ptr], the oldest sample.
//     S_READ:   oldest = primed ? rd_data : 0.
//               sum <= sum + sext(new) - sext(oldest); buf[wr_ptr] <= new.
//     S_UPDATE: wr_ptr++ (wraps modulo 2^LOG2_N); fill++ saturating at 2^LOG2_N.
//               If fill reaches 2^LOG2_N (counting this sample), o_primed<=1.
//               When primed: o_avg <= sum >>> LOG2_N (arithmetic shift, floor toward -inf)
//               and o_avg_valid pulses.
//   Latency: i_valid in cycle T -> o_avg_valid in cycle T+3. Minimum input spacing is 3 cycles.
//   Overrun: i_valid outside S_IDLE is dropped; o_overrun pulses in the next cycle.
//   Sum width: 16+LOG2_N bits, signed; overflow is impossible by construction.
//   Before primed: samples accumulate and no o_avg_valid is produced. o_avg holds its last value.
//   i_clear: highest priority after reset. Any cycle it is high:
//     - state, wr_ptr, fill, sum, o_primed go to 0/S_IDLE; an in-flight sample is discarded.
//     - no o_avg_valid is produced; o_avg holds its value.
//     - a coincident i_valid is ignored, and no overrun is flagged.
//   i_rst mid-operation: identical to reset values; a pending output is never emitted.
// CONFIGURATION
//   Macro ADS1115_AVG_MINMAX_EN.
//   Defined:
//     - o_min/o_max track signed extremes of every accepted raw sample (not averages).
//     - Both load the first sample after reset or i_clear; updated in S_UPDATE.
//   Undefined: o_min/o_max ports are absent and no comparators are built.
// STRUCTURE
//   Shared include ads1115_defs.vh:
//     - FSM state localparams.
//     - ADS_SAMPLE_W=16.
//     - Full-scale constants (+32767 / -32768, 4.096 V at gain 1).
//   Sub-module avg_sample_ram:
//     - simple dual-port RAM, 2^LOG2_N x 16, one write port, registered read, no reset.
//     - infers iCE40 EBR for LOG2_N>=5.
//   All pointer, count and sum logic stays in the top module.
// TESTING
//   1. Reset, then 16 samples of +1000 at 100-cycle spacing.
//      -> o_primed rises on sample 16; one o_avg_valid with o_avg=1000;
//         no valid on samples 1-15.
//   2. Primed at 1000, then 8 samples of -2000.
//      -> 8th output o_avg=-500 (sum -8000).
//      -> After 16 samples o_avg=-2000, confirming pointer wrap.
//   3. Window of alternating -1, 0 (sum -8).
//      -> o_avg=-1 (floor of -0.5), never 0.
//      Window of all 16'h8000 -> o_avg=-32768.
//      Window of all 16'h7FFF -> o_avg=32767.
//   4. Two i_valid pulses 1 cycle apart.
//      -> second dropped; o_overrun pulses once; sum reflects only the first.
//   5. i_clear asserted in S_READ.
//      -> no o_avg_valid; o_primed=0; next 15 samples produce no output; 16th produces avg.
//   6. With ADS1115_AVG_MINMAX_EN: samples 5, -300, 7000, 12.
//      -> o_min=-300, o_max=7000.
//      -> After i_clear plus sample 42: o_min=o_max=42.

Source files
------------

// File: rtl/ads1115_avg_filter_pkg.sv
// Shared ADS1115 filter definitions: sample width, full-scale codes and FSM states.
package ads1115_avg_filter_pkg;

  localparam int ADS_SAMPLE_W = 16;

  // Full-scale codes at gain 1 (+/-4.096 V)
  localparam logic signed [ADS_SAMPLE_W-1:0] ADS_FS_POS      = 16'sh7FFF;
  localparam logic signed [ADS_SAMPLE_W-1:0] ADS_FS_NEG      = 16'sh8000;
  localparam int                             ADS_FS_MV_GAIN1 = 4096;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

endpackage

// File: rtl/ads1115_avg_filter_ram.sv
// Window sample store: simple dual-port RAM, one write port, registered read, no reset.
module avg_sample_ram #(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ads1115_avg_filter.sv
// Boxcar average over 2^LOG2_N samples; i_valid -> o_avg_valid in 3 cycles, inputs arriving
// while busy are dropped and flagged on o_overrun. Min/max tracking under ADS1115_AVG_MINMAX_EN.
module ads1115_avg_filter
  import ads1115_avg_filter_pkg::*;
#(
  parameter int unsigned LOG2_N = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic signed [ADS_SAMPLE_W-1:0] i_data,
  input  logic                           i_valid,
  input  logic                           i_clear,
  output logic signed [ADS_SAMPLE_W-1:0] o_avg,
  output logic                           o_avg_valid,
  output logic                           o_primed,
  output logic                           o_overrun
`ifdef ADS1115_AVG_MINMAX_EN
  ,
  output logic signed [ADS_SAMPLE_W-1:0] o_min,
  output logic signed [ADS_SAMPLE_W-1:0] o_max
`endif
);

  localparam int SUM_W  = ADS_SAMPLE_W + LOG2_N;
  localparam int FILL_W = LOG2_N + 1;
  localparam logic [FILL_W-1:0] FULL = {1'b1, {LOG2_N{1'b0}}};

  state_t state_q, state_d;
  logic   take_s, read_s, upd_s, drop_s;

  logic signed [ADS_SAMPLE_W-1:0] sample_q, sample_d;
  logic signed [ADS_SAMPLE_W-1:0] avg_q, avg_d;
  logic signed [ADS_SAMPLE_W-1:0] oldest;
  logic        [ADS_SAMPLE_W-1:0] rd_data;
  logic signed [SUM_W-1:0]        sum_q, sum_d;
  logic        [LOG2_N-1:0]       wr_ptr_q, wr_ptr_d;
  logic        [FILL_W-1:0]       fill_q, fill_d;
  logic                           primed_q, primed_d;
  logic                           avg_vld_q, avg_vld_d;
  logic                           ovr_q, ovr_d;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) state_q <= S_IDLE;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_valid) state_d = S_READ;
      S_READ:   state_d = S_UPDATE;
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    take_s = 1'b0;
    read_s = 1'b0;
    upd_s  = 1'b0;
    drop_s = 1'b0;
    if (!i_clear) begin
      case (state_q)
        S_IDLE:   take_s = i_valid;
        S_READ:   begin read_s = 1'b1; drop_s = i_valid; end
        S_UPDATE: begin upd_s  = 1'b1; drop_s = i_valid; end
        default:  drop_s = i_valid;
      endcase
    end
  end

  // Read slot wr_ptr is the oldest sample once the window has wrapped
  avg_sample_ram #(.AW(LOG2_N), .DW(ADS_SAMPLE_W)) u_ram (
    .clk_i     (i_clk),
    .wr_en_i   (read_s),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (sample_q),
    .rd_en_i   (take_s),
    .rd_addr_i (wr_ptr_q),
    .rd_data_o (rd_data)
  );

  assign oldest = primed_q ? $signed(rd_data) : '0;

  always_comb begin
    sample_d  = sample_q;
    sum_d     = sum_q;
    wr_ptr_d  = wr_ptr_q;
    fill_d    = fill_q;
    primed_d  = primed_q;
    avg_d     = avg_q;
    avg_vld_d = 1'b0;
    ovr_d     = drop_s;
    if (take_s) sample_d = i_data;
    if (read_s)
      sum_d = sum_q + {{LOG2_N{sample_q[ADS_SAMPLE_W-1]}}, sample_q}
                    - {{LOG2_N{oldest[ADS_SAMPLE_W-1]}}, oldest};
    if (upd_s) begin
      wr_ptr_d = wr_ptr_q + LOG2_N'(1);
      fill_d   = (fill_q == FULL) ? fill_q : fill_q + FILL_W'(1);
      if (fill_d == FULL) begin
        primed_d  = 1'b1;
        // Top bits of the sum are the floor of sum / 2^LOG2_N
        avg_d     = sum_q[SUM_W-1 -: ADS_SAMPLE_W];
        avg_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sample_q  <= '0;
      sum_q     <= '0;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      primed_q  <= 1'b0;
      avg_q     <= '0;
      avg_vld_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else if (i_clear) begin
      sum_q     <= '0;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      primed_q  <= 1'b0;
      avg_vld_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sample_q  <= sample_d;
      sum_q     <= sum_d;
      wr_ptr_q  <= wr_ptr_d;
      fill_q    <= fill_d;
      primed_q  <= primed_d;
      avg_q     <= avg_d;
      avg_vld_q <= avg_vld_d;
      ovr_q     <= ovr_d;
    end
  end

  assign o_avg       = avg_q;
  assign o_avg_valid = avg_vld_q;
  assign o_primed    = primed_q;
  assign o_overrun   = ovr_q;

`ifdef ADS1115_AVG_MINMAX_EN
  logic                           mm_vld_q, mm_vld_d;
  logic signed [ADS_SAMPLE_W-1:0] min_q, min_d, max_q, max_d;

  always_comb begin
    mm_vld_d = mm_vld_q;
    min_d    = min_q;
    max_d    = max_q;
    if (upd_s) begin
      mm_vld_d = 1'b1;
      if (!mm_vld_q || sample_q < min_q) min_d = sample_q;
      if (!mm_vld_q || sample_q > max_q) max_d = sample_q;
    end
  end

  // Extremes hold across a clear until the next accepted sample reloads them
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mm_vld_q <= 1'b0;
      min_q    <= '0;
      max_q    <= '0;
    end else if (i_clear) begin
      mm_vld_q <= 1'b0;
    end else begin
      mm_vld_q <= mm_vld_d;
      min_q    <= min_d;
      max_q    <= max_d;
    end
  end

  assign o_min = min_q;
  assign o_max = max_q;
`endif

endmodule

// File: tb/tb_ads1115_avg_filter.sv
// Scoreboard bench for ads1115_avg_filter: directed windows with hand-computed averages.
module tb_ads1115_avg_filter;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] din = '0;
  logic               vld = 1'b0;
  logic               clr = 1'b0;
  logic signed [15:0] avg;
  logic               avg_vld, primed, ovr;
`ifdef ADS1115_AVG_MINMAX_EN
  logic signed [15:0] mn, mx;
`endif

  ads1115_avg_filter #(.LOG2_N(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_data      (din),
    .i_valid     (vld),
    .i_clear     (clr),
    .o_avg       (avg),
    .o_avg_valid (avg_vld),
    .o_primed    (primed),
    .o_overrun   (ovr)
`ifdef ADS1115_AVG_MINMAX_EN
    ,
    .o_min       (mn),
    .o_max       (mx)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] avg;
    int                 cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc     = 0;
  int   n_vec   = 0;
  int   n_mis   = 0;
  int   ovr_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every averaged output must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (ovr) ovr_cnt++;
    if (avg_vld) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_avg_valid", int'(avg), 99999);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("avg_value", int'(avg), int'(e.avg));
        chk("avg_latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic send(input logic signed [15:0] d, input bit exp_v,
                      input logic signed [15:0] exp_avg, input int gap);
    @(posedge clk); #1;
    din = d;
    vld = 1'b1;
    if (exp_v) exp_q.push_back('{avg: exp_avg, cyc: cyc + 3});
    @(posedge clk); #1;
    vld = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic clear_pulse();
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // Window 16x(+1000), then k samples of -2000: floor((16000 - 3000k) / 16)
  logic signed [15:0] t2_exp [16] = '{
    16'sd812,   16'sd625,   16'sd437,   16'sd250,
    16'sd62,   -16'sd125,  -16'sd313,  -16'sd500,
    -16'sd688, -16'sd875,  -16'sd1063, -16'sd1250,
    -16'sd1438, -16'sd1625, -16'sd1813, -16'sd2000
  };

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ovr_base;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_avg", int'(avg), 0);
    chk("reset_avg_valid", int'(avg_vld), 0);
    chk("reset_primed", int'(primed), 0);
    chk("reset_overrun", int'(ovr), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // 1: fill window with +1000; only the 16th sample produces output
    for (int k = 1; k <= 16; k++) begin
      send(16'sd1000, k == 16, 16'sd1000, 98);
      if (k == 15) chk("primed_after_15", int'(primed), 0);
    end
    chk("primed_after_16", int'(primed), 1);

    // 2: replace with -2000, checking every intermediate average and pointer wrap
    for (int k = 0; k < 16; k++) send(-16'sd2000, 1'b1, t2_exp[k], 6);
    chk("avg_after_wrap", int'(avg), -2000);

    // 4: second strobe one cycle after the first is dropped
    ovr_base = ovr_cnt;
    @(posedge clk); #1;
    din = 16'sd14000;
    vld = 1'b1;
    exp_q.push_back('{avg: -16'sd1000, cyc: cyc + 3});
    @(posedge clk); #1;
    din = 16'sd9999;
    @(posedge clk); #1;
    vld = 1'b0;
    repeat (8) @(posedge clk);
    chk("overrun_pulses", ovr_cnt - ovr_base, 1);
    send(-16'sd2000, 1'b1, -16'sd1000, 6);
    chk("no_extra_overrun", ovr_cnt - ovr_base, 1);

    // 5: clear while the sample is in S_READ discards it and restarts the fill
    @(posedge clk); #1;
    din = 16'sd500;
    vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("primed_after_clear", int'(primed), 0);
    chk("avg_holds_after_clear", int'(avg), -1000);
    for (int k = 1; k <= 16; k++) send(16'sd100, k == 16, 16'sd100, 6);

    // 3: rounding toward -inf and full-scale windows
    clear_pulse();
    for (int k = 0; k < 16; k++) send((k % 2 == 0) ? -16'sd1 : 16'sd0, k == 15, -16'sd1, 6);
    clear_pulse();
    for (int k = 0; k < 16; k++) send(16'sh8000, k == 15, 16'sh8000, 6);
    clear_pulse();
    for (int k = 0; k < 16; k++) send(16'sh7FFF, k == 15, 16'sh7FFF, 6);

    // Coincident clear and strobe: no sample taken, no overrun
    ovr_base = ovr_cnt;
    @(posedge clk); #1;
    din = 16'sd7;
    vld = 1'b1;
    clr = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0;
    clr = 1'b0;
    repeat (6) @(posedge clk);
    chk("clear_with_valid_no_overrun", ovr_cnt - ovr_base, 0);
    chk("clear_with_valid_not_primed", int'(primed), 0);

`ifdef ADS1115_AVG_MINMAX_EN
    // 6: raw-sample extremes
    clear_pulse();
    send(16'sd5, 1'b0, 16'sd0, 6);
    send(-16'sd300, 1'b0, 16'sd0, 6);
    send(16'sd7000, 1'b0, 16'sd0, 6);
    send(16'sd12, 1'b0, 16'sd0, 6);
    #1;
    chk("min_four_samples", int'(mn), -300);
    chk("max_four_samples", int'(mx), 7000);
    clear_pulse();
    send(16'sd42, 1'b0, 16'sd0, 6);
    #1;
    chk("min_after_clear", int'(mn), 42);
    chk("max_after_clear", int'(mx), 42);
`endif

    repeat (20) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
